// File: rtl/ins_mem_loader_if.sv
// rtl/ins_mem_loader_if.sv - byte stream in, word write bus out, for the instruction memory loader
interface ins_mem_loader_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_byte, in_valid, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_byte, in_valid, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - packs a byte stream into 32-bit words and writes the instruction memory
// First byte of each word lands in bits[31:24]; an early last zero-fills the remaining words.
module ins_mem_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    ins_mem_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             word_end;
    logic             at_top;
    logic [CNT_W-1:0] word_idx_inc;
    logic [31:0]      packed_word;

    assign xfer         = bus.in_valid && (state_q == LOAD);
    assign word_end     = xfer && ((byte_idx_q == 2'd3) || bus.in_last);
    assign at_top       = (word_idx_q == CNT_W'(DEPTH - 1));
    assign word_idx_inc = word_idx_q + CNT_W'(1);

    // Missing low bytes stay zero because word_q is cleared at every word boundary.
    always_comb begin
        packed_word = word_q;
        case (byte_idx_q)
            2'd0:    packed_word[31:24] = bus.in_byte;
            2'd1:    packed_word[23:16] = bus.in_byte;
            2'd2:    packed_word[15:8]  = bus.in_byte;
            default: packed_word[7:0]   = bus.in_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            word_count_q <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            word_q       <= word_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (word_end) state_d = WRITE;
            WRITE: begin
                if (at_top)      state_d = DONE;
                else if (last_q) state_d = FILL;
                else             state_d = LOAD;
            end
            FILL:    if (at_top) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so wr_en lines up with WRITE/FILL.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        word_d       = word_q;
        last_d       = last_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    byte_idx_d   = '0;
                    word_idx_d   = '0;
                    word_count_d = '0;
                    word_d       = '0;
                    last_d       = 1'b0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    word_d     = packed_word;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
                if (word_end) begin
                    last_d    = bus.in_last;
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'(word_idx_q) << 2;
                    wr_data_d = packed_word;
                end
            end
            WRITE, FILL: begin
                word_idx_d = word_idx_inc;
                if (state_q == WRITE) begin
                    word_count_d = word_count_q + CNT_W'(1);
                    byte_idx_d   = '0;
                    word_d       = '0;
                end
                if (state_d == FILL) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'(word_idx_inc) << 2;
                    wr_data_d = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == LOAD) || (state_d == WRITE) || (state_d == FILL);
        done_d = (state_d == DONE);
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_count   = word_count_q;

endmodule
